// File: rtl/neuron_pkg.sv
// Shared types and widths for the perceptron sample sequencer and its buffer.
package neuron_pkg;

    localparam int X_W      = 7;
    localparam int T_W      = 2;
    localparam int N_W      = 32;
    localparam int SAMPLE_W = 2 * X_W + T_W;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_REQ,
        SERVE,
        WAIT_REL,
        TIMEOUT
    } state_e;

    typedef struct packed {
        logic [X_W-1:0] x1;
        logic [X_W-1:0] x2;
        logic [T_W-1:0] t;
    } sample_t;

endpackage

// File: rtl/neuron_sample_buffer.sv
// Host-loaded sample register file: one synchronous write port, one combinational read port.
module neuron_sample_buffer
    import neuron_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                we_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [SAMPLE_W-1:0] wdata_i,
    input  logic [AW-1:0]       raddr_i,
    output logic [SAMPLE_W-1:0] rdata_o
);

    logic [SAMPLE_W-1:0] mem_q [DEPTH];

    // The clear wipes every entry so a reset run never sees stale samples.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (int'(waddr_i) < DEPTH)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/neuron_sample_sequencer.sv
// Feeds buffered training samples to the Neuron on request and sequences a full training run.
module neuron_sample_sequencer
    import neuron_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int AW         = 6,
    parameter int EW         = 8,
    parameter int MAX_EPOCHS = 200
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  logic [X_W-1:0] wr_x1,
    input  logic [X_W-1:0] wr_x2,
    input  logic [T_W-1:0] wr_t,
    input  logic [AW:0]    cfg_n,
    input  logic           go,
    output logic           n_start,
    output logic           n_clear,
    output logic [N_W-1:0] n_count,
    output logic [X_W-1:0] n_x1,
    output logic [X_W-1:0] n_x2,
    output logic [T_W-1:0] n_t,
    output logic           n_dataReady,
    input  logic           n_requestFlag,
    input  logic           n_done,
    output logic           busy,
    output logic           finished,
    output logic           timeout,
    output logic           cfg_err,
    output logic [EW-1:0]  epoch_count
);

    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE_N   = (AW + 1)'(1);
    localparam logic [EW-1:0] MAX_E   = EW'(MAX_EPOCHS);

    state_e          state_q;
    logic [AW-1:0]   idx_q,   idx_d;
    logic [EW-1:0]   epoch_q, epoch_d;
    logic [AW:0]     cfg_q;
    logic            start_q, clear_q, ready_q, busy_q;
    logic            finished_q, timeout_q, cfg_err_q;
    logic [X_W-1:0]  x1_q, x2_q;
    logic [T_W-1:0]  t_q;
    logic            last_idx, hit_limit, cfg_ok, buf_we;
    logic [SAMPLE_W-1:0] rd_raw;
    sample_t         rd_s;

    assign buf_we = wr_en && (state_q == IDLE);
    assign cfg_ok = (cfg_n != '0) && (cfg_n <= DEPTH_C);

    neuron_sample_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk_i   (clk),
        .rst_ni  (rst),
        .we_i    (buf_we),
        .waddr_i (wr_addr),
        .wdata_i ({wr_x1, wr_x2, wr_t}),
        .raddr_i (idx_q),
        .rdata_o (rd_raw)
    );

    assign rd_s = sample_t'(rd_raw);

    // Index and epoch advance computed once here; the FSM commits them when leaving SERVE.
    always_comb begin
        last_idx  = ({1'b0, idx_q} == (cfg_q - ONE_N));
        idx_d     = idx_q + AW'(1);
        epoch_d   = epoch_q;
        hit_limit = 1'b0;
        if (last_idx) begin
            idx_d     = '0;
            epoch_d   = epoch_q + EW'(1);
            hit_limit = (epoch_d == MAX_E);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            epoch_q    <= '0;
            cfg_q      <= '0;
            start_q    <= 1'b0;
            clear_q    <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
            timeout_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
            x1_q       <= '0;
            x2_q       <= '0;
            t_q        <= '0;
        end else begin
            start_q <= 1'b0;
            clear_q <= 1'b0;
            ready_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (go) begin
                        if (cfg_ok) begin
                            cfg_q      <= cfg_n;
                            epoch_q    <= '0;
                            idx_q      <= '0;
                            finished_q <= 1'b0;
                            timeout_q  <= 1'b0;
                            cfg_err_q  <= 1'b0;
                            start_q    <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= START;
                        end else begin
                            cfg_err_q  <= 1'b1;
                        end
                    end
                end
                START: state_q <= WAIT_REQ;
                WAIT_REQ: begin
                    // Done wins over a coincident request so no sample leaks after completion.
                    if (n_done) begin
                        finished_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else if (n_requestFlag) begin
                        x1_q    <= rd_s.x1;
                        x2_q    <= rd_s.x2;
                        t_q     <= rd_s.t;
                        ready_q <= 1'b1;
                        state_q <= SERVE;
                    end
                end
                SERVE: begin
                    idx_q   <= idx_d;
                    epoch_q <= epoch_d;
                    if (hit_limit) begin
                        clear_q   <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= TIMEOUT;
                    end else begin
                        state_q   <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (n_done) begin
                        finished_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else if (!n_requestFlag) begin
                        state_q    <= WAIT_REQ;
                    end
                end
                TIMEOUT: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign n_start     = start_q;
    assign n_clear     = clear_q;
    assign n_dataReady = ready_q;
    assign n_count     = {{(N_W - AW - 1){1'b0}}, cfg_q};
    assign n_x1        = x1_q;
    assign n_x2        = x2_q;
    assign n_t         = t_q;
    assign busy        = busy_q;
    assign finished    = finished_q;
    assign timeout     = timeout_q;
    assign cfg_err     = cfg_err_q;
    assign epoch_count = epoch_q;

endmodule

// File: tb/tb_neuron_sample_sequencer.sv
// Scoreboard bench for the sample sequencer with a small Neuron request model.
module tb_neuron_sample_sequencer;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int EW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [6:0]    wr_x1 = '0, wr_x2 = '0;
    logic [1:0]    wr_t = '0;
    logic [AW:0]   cfg_n = '0;
    logic          go = 1'b0;
    logic          n_requestFlag = 1'b0;
    logic          n_done = 1'b0;
    logic          n_start, n_clear, n_dataReady, busy, finished, timeout, cfg_err;
    logic [31:0]   n_count;
    logic [6:0]    n_x1, n_x2;
    logic [1:0]    n_t;
    logic [EW-1:0] epoch_count;

    neuron_sample_sequencer #(
        .DEPTH(DEPTH), .AW(AW), .EW(EW), .MAX_EPOCHS(3)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_x1(wr_x1), .wr_x2(wr_x2), .wr_t(wr_t), .cfg_n(cfg_n), .go(go),
        .n_start(n_start), .n_clear(n_clear), .n_count(n_count),
        .n_x1(n_x1), .n_x2(n_x2), .n_t(n_t), .n_dataReady(n_dataReady),
        .n_requestFlag(n_requestFlag), .n_done(n_done), .busy(busy),
        .finished(finished), .timeout(timeout), .cfg_err(cfg_err),
        .epoch_count(epoch_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          dr_cnt = 0, start_cnt = 0, clr_cnt = 0;
    logic [15:0] sb_q[$];
    logic [15:0] mem_m [DEPTH];
    int          idx_m = 0, ep_m = 0, cfg_m = 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (n_start) start_cnt++;
        if (n_clear) clr_cnt++;
        if (n_dataReady) begin
            dr_cnt++;
            if (sb_q.size() == 0) begin
                check_val("dr_unexpected", 32'(sb_q.size()), 32'd1);
            end else begin
                logic [15:0] e;
                e = sb_q.pop_front();
                check_val("sample", {16'd0, n_x1, n_x2, n_t}, {16'd0, e});
            end
        end
    end

    task automatic host_write(input int a, input logic [6:0] x1, input logic [6:0] x2,
                              input logic [1:0] t, input bit accept);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = AW'(a); wr_x1 = x1; wr_x2 = x2; wr_t = t;
        @(negedge clk);
        wr_en = 1'b0;
        if (accept) mem_m[a] = {x1, x2, t};
    endtask

    task automatic do_go(input int n, input bit valid);
        @(negedge clk);
        cfg_n = (AW + 1)'(n); go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        if (valid) begin
            cfg_m = n; idx_m = 0; ep_m = 0;
        end
    endtask

    task automatic push_expected();
        sb_q.push_back(mem_m[idx_m]);
        idx_m++;
        if (idx_m == cfg_m) begin
            idx_m = 0;
            ep_m++;
        end
    endtask

    task automatic serve_one();
        @(negedge clk);
        n_requestFlag = 1'b1;
        push_expected();
        @(negedge clk);
        check_val("dr_latency", 32'(n_dataReady), 32'd1);
        n_requestFlag = 1'b0;
        @(negedge clk);
        check_val("dr_width", 32'(n_dataReady), 32'd0);
    endtask

    task automatic end_run();
        @(negedge clk);
        n_done = 1'b1;
        @(negedge clk);
        n_done = 1'b0;
        check_val("end_finished", 32'(finished), 32'd1);
        check_val("end_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_start", 32'(n_start), 32'd0);
        check_val("rst_dr", 32'(n_dataReady), 32'd0);
        check_val("rst_epoch", 32'(epoch_count), 32'd0);
        check_val("rst_count", n_count, 32'd0);
        check_val("rst_flags", {29'd0, finished, timeout, cfg_err}, 32'd0);
        rst = 1'b1;

        // Four samples, ten in-order serves across epochs
        for (int i = 0; i < 4; i++)
            host_write(i, 7'(10 + 11 * i), 7'(100 - 7 * i), 2'(i), 1'b1);
        do_go(4, 1'b1);
        check_val("start_pulses", 32'(start_cnt), 32'd1);
        check_val("count_latched", n_count, 32'd4);
        check_val("run_busy", 32'(busy), 32'd1);
        host_write(2, 7'h7f, 7'h7f, 2'd3, 1'b0);
        for (int i = 0; i < 10; i++) serve_one();
        check_val("epoch_after10", 32'(epoch_count), 32'(ep_m));
        check_val("start_once", 32'(start_cnt), 32'd1);
        end_run();

        // Held request produces one serve only
        do_go(4, 1'b1);
        @(negedge clk);
        n_requestFlag = 1'b1;
        push_expected();
        d0 = dr_cnt;
        repeat (5) @(negedge clk);
        n_requestFlag = 1'b0;
        check_val("hold_single", 32'(dr_cnt - d0), 32'd1);
        @(negedge clk);
        serve_one();

        // Done and request together: no serve, run ends
        @(negedge clk);
        n_requestFlag = 1'b1; n_done = 1'b1;
        d0 = dr_cnt;
        @(negedge clk);
        check_val("dr_vs_done", 32'(n_dataReady), 32'd0);
        check_val("done_finished", 32'(finished), 32'd1);
        check_val("done_idle", 32'(busy), 32'd0);
        n_requestFlag = 1'b0; n_done = 1'b0;
        @(negedge clk);
        check_val("no_late_dr", 32'(dr_cnt), 32'(d0));

        // Invalid configurations
        do_go(0, 1'b0);
        check_val("err_zero", 32'(cfg_err), 32'd1);
        check_val("err_zero_busy", 32'(busy), 32'd0);
        do_go(65, 1'b0);
        check_val("err_big", 32'(cfg_err), 32'd1);
        check_val("err_big_busy", 32'(busy), 32'd0);
        do_go(2, 1'b1);
        check_val("err_cleared", 32'(cfg_err), 32'd0);
        check_val("fin_cleared", 32'(finished), 32'd0);

        // Epoch limit timeout (limit 3, two samples)
        d0 = clr_cnt;
        for (int i = 0; i < 6; i++) serve_one();
        @(negedge clk);
        check_val("clr_pulses", 32'(clr_cnt - d0), 32'd1);
        check_val("to_flag", 32'(timeout), 32'd1);
        check_val("to_busy", 32'(busy), 32'd0);
        check_val("to_epoch", 32'(epoch_count), 32'd3);
        check_val("to_not_fin", 32'(finished), 32'd0);

        // Asynchronous reset mid-serve, with an ignored busy write beforehand
        do_go(4, 1'b1);
        host_write(0, 7'h55, 7'h2a, 2'd1, 1'b0);
        @(negedge clk);
        n_requestFlag = 1'b1;
        push_expected();
        @(negedge clk);
        check_val("pre_rst_dr", 32'(n_dataReady), 32'd1);
        #1 rst = 1'b0;
        #1;
        check_val("arst_dr", 32'(n_dataReady), 32'd0);
        check_val("arst_busy", 32'(busy), 32'd0);
        check_val("arst_data", {16'd0, n_x1, n_x2, n_t}, 32'd0);
        check_val("arst_count", n_count, 32'd0);
        n_requestFlag = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        do_go(2, 1'b1);
        serve_one();
        serve_one();
        end_run();

        repeat (2) @(negedge clk);
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
